// File: rtl/execute_branch_port_ng.sv
// execute_branch_port_ng
//
// Purpose:
//   Branch execution port. Takes one resolved branch-class operation per
//   cycle from the branch scheduler, returns its completion tag one cycle
//   later and checks jumps against the front-end prediction. Any operation
//   that must steer the front end raises a redirect through a valid/ready
//   handshake. After the redirect is taken, the port sits in a wrong-path
//   shadow until the pipeline restart arrives. It also keeps a saturating
//   count of jump mispredictions.
//
// Parameters:
//   ADDR_W     width of PC / target / redirect address
//   TAG_W      commit tag width
//   CNT_W      misprediction counter width
//   CHECK_PRED 1: jumps redirect only on mispredict, 0: every taken jump redirects
//
// Ports:
//   iCLOCK, iRESET            clock, asynchronous active-high reset
//   iFREE_RESTART             synchronous pipeline restart / flush
//   iREQ_*                    request from the branch scheduler
//   oREQ_LOCK                 port busy, request not accepted this cycle
//   oCMP_VALID / oCMP_TAG     one-cycle completion pulse to schedulers
//   oREDIRECT_* / iREDIRECT_READY  redirect handshake to the front end
//   oMISPRED_CNT              saturating jump-misprediction count

module execute_branch_port_ng #(
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 6,
    parameter int CNT_W      = 16,
    parameter bit CHECK_PRED = 1'b1
) (
    input  logic              iCLOCK,
    input  logic              iRESET,
    input  logic              iFREE_RESTART,
    input  logic              iREQ_VALID,
    output logic              oREQ_LOCK,
    input  logic [TAG_W-1:0]  iREQ_TAG,
    input  logic [1:0]        iREQ_KIND,
    input  logic              iREQ_TAKEN,
    input  logic [ADDR_W-1:0] iREQ_PC,
    input  logic [ADDR_W-1:0] iREQ_TARGET,
    input  logic              iREQ_PRED_TAKEN,
    input  logic [ADDR_W-1:0] iREQ_PRED_ADDR,
    input  logic [10:0]       iREQ_SWI_NUM,
    output logic              oCMP_VALID,
    output logic [TAG_W-1:0]  oCMP_TAG,
    output logic              oREDIRECT_VALID,
    input  logic              iREDIRECT_READY,
    output logic [1:0]        oREDIRECT_KIND,
    output logic [ADDR_W-1:0] oREDIRECT_ADDR,
    output logic [TAG_W-1:0]  oREDIRECT_TAG,
    output logic [10:0]       oREDIRECT_SWI_NUM,
    output logic [CNT_W-1:0]  oMISPRED_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    localparam logic [1:0] KIND_JUMP = 2'd0;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_cmp_valid;
    logic [TAG_W-1:0]    r_cmp_tag;
    logic [1:0]          r_redirect_kind;
    logic [ADDR_W-1:0]   r_redirect_addr;
    logic [TAG_W-1:0]    r_redirect_tag;
    logic [10:0]         r_redirect_swi_num;
    logic [CNT_W-1:0]    r_mispred_cnt;

    logic                w_accept;
    logic                w_is_jump;
    logic                w_mispred;
    logic                w_redirect;
    logic [ADDR_W-1:0]   w_pc_plus4;
    logic [ADDR_W-1:0]   w_redirect_addr;
    logic                w_cnt_saturated;

    // Lock is a function of the registered state alone, so the scheduler
    // never sees a combinational path from this cycle's inputs.
    assign oREQ_LOCK       = (r_state != ST_IDLE);
    assign oREDIRECT_VALID = (r_state == ST_PEND);

    // A restart in the same cycle kills the request outright.
    assign w_accept  = iREQ_VALID && (r_state == ST_IDLE) && !iFREE_RESTART;
    assign w_is_jump = (iREQ_KIND == KIND_JUMP);

    assign w_mispred = (iREQ_TAKEN != iREQ_PRED_TAKEN) ||
                       (iREQ_TAKEN && (iREQ_TARGET != iREQ_PRED_ADDR));

    // Non-jump kinds always steer the front end. In legacy mode a jump
    // redirects whenever it is taken, whatever the prediction was.
    assign w_redirect = !w_is_jump || (CHECK_PRED ? w_mispred : iREQ_TAKEN);

    // The only case that does not redirect to the resolved target is a
    // not-taken jump that was predicted taken: fall through to PC+4.
    assign w_pc_plus4      = iREQ_PC + ADDR_W'(4);
    assign w_redirect_addr = (w_is_jump && !iREQ_TAKEN) ? w_pc_plus4 : iREQ_TARGET;

    assign w_cnt_saturated = (r_mispred_cnt == {CNT_W{1'b1}});

    // State register.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Restart overrides everything, including a redirect
    // being accepted by the consumer in the same cycle.
    always_comb begin
        w_next_state = r_state;
        if (iFREE_RESTART) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_redirect) begin
                        w_next_state = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (iREDIRECT_READY) begin
                        w_next_state = ST_SHADOW;
                    end
                end
                ST_SHADOW: begin
                    w_next_state = ST_SHADOW;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Completion pulse: one cycle after every accepted op. The tag register
    // only updates on accept, so it holds its last value otherwise.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_cmp_valid <= 1'b0;
            r_cmp_tag   <= '0;
        end else begin
            r_cmp_valid <= w_accept;
            if (w_accept) begin
                r_cmp_tag <= iREQ_TAG;
            end
        end
    end

    // Redirect payload is captured with the accepting op and then left
    // alone, which keeps it stable for as long as the handshake is pending.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_redirect_kind    <= '0;
            r_redirect_addr    <= '0;
            r_redirect_tag     <= '0;
            r_redirect_swi_num <= '0;
        end else if (w_accept && w_redirect) begin
            r_redirect_kind    <= iREQ_KIND;
            r_redirect_addr    <= w_redirect_addr;
            r_redirect_tag     <= iREQ_TAG;
            r_redirect_swi_num <= iREQ_SWI_NUM;
        end
    end

    // Misprediction statistics count every accepted mispredicted jump in
    // both modes, stick at the maximum, and are cleared only by reset.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_mispred_cnt <= '0;
        end else if (w_accept && w_is_jump && w_mispred && !w_cnt_saturated) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

    assign oCMP_VALID        = r_cmp_valid;
    assign oCMP_TAG          = r_cmp_tag;
    assign oREDIRECT_KIND    = r_redirect_kind;
    assign oREDIRECT_ADDR    = r_redirect_addr;
    assign oREDIRECT_TAG     = r_redirect_tag;
    assign oREDIRECT_SWI_NUM = r_redirect_swi_num;
    assign oMISPRED_CNT      = r_mispred_cnt;

endmodule

// File: tb/tb_execute_branch_port_ng.sv
// tb_execute_branch_port_ng
//
// Purpose:
//   Testbench for execute_branch_port_ng. It drives two instances from the
//   same stimulus: the default configuration and a narrow-counter copy used
//   to exercise counter saturation. A behavioural model of the port's rules
//   predicts every output cycle by cycle.
//
// Ports: none (top-level bench).

module tb_execute_branch_port_ng;

    logic        clock;
    logic        reset;
    logic        freeRestart;
    logic        reqValid;
    logic [5:0]  reqTag;
    logic [1:0]  reqKind;
    logic        reqTaken;
    logic [31:0] reqPc;
    logic [31:0] reqTarget;
    logic        reqPredTaken;
    logic [31:0] reqPredAddr;
    logic [10:0] reqSwiNum;
    logic        redirectReady;

    logic        reqLock;
    logic        cmpValid;
    logic [5:0]  cmpTag;
    logic        redirValid;
    logic [1:0]  redirKind;
    logic [31:0] redirAddr;
    logic [5:0]  redirTag;
    logic [10:0] redirSwi;
    logic [15:0] mispredCnt;

    logic        satLock;
    logic        satCmpValid;
    logic [5:0]  satCmpTag;
    logic        satRedirValid;
    logic [1:0]  satRedirKind;
    logic [31:0] satRedirAddr;
    logic [5:0]  satRedirTag;
    logic [10:0] satRedirSwi;
    logic [1:0]  satCnt;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the port: what is pending, what was latched.
    bit          mPend;
    bit          mShadow;
    bit          mCmpValid;
    logic [5:0]  mCmpTag;
    logic [1:0]  mKind;
    logic [31:0] mAddr;
    logic [5:0]  mTag;
    logic [10:0] mSwi;
    int unsigned mCnt;
    int unsigned mCntSat;

    execute_branch_port_ng #(.ADDR_W(32), .TAG_W(6), .CNT_W(16), .CHECK_PRED(1'b1)) dut (
        .iCLOCK            (clock),
        .iRESET            (reset),
        .iFREE_RESTART     (freeRestart),
        .iREQ_VALID        (reqValid),
        .oREQ_LOCK         (reqLock),
        .iREQ_TAG          (reqTag),
        .iREQ_KIND         (reqKind),
        .iREQ_TAKEN        (reqTaken),
        .iREQ_PC           (reqPc),
        .iREQ_TARGET       (reqTarget),
        .iREQ_PRED_TAKEN   (reqPredTaken),
        .iREQ_PRED_ADDR    (reqPredAddr),
        .iREQ_SWI_NUM      (reqSwiNum),
        .oCMP_VALID        (cmpValid),
        .oCMP_TAG          (cmpTag),
        .oREDIRECT_VALID   (redirValid),
        .iREDIRECT_READY   (redirectReady),
        .oREDIRECT_KIND    (redirKind),
        .oREDIRECT_ADDR    (redirAddr),
        .oREDIRECT_TAG     (redirTag),
        .oREDIRECT_SWI_NUM (redirSwi),
        .oMISPRED_CNT      (mispredCnt)
    );

    execute_branch_port_ng #(.ADDR_W(32), .TAG_W(6), .CNT_W(2), .CHECK_PRED(1'b1)) dutSat (
        .iCLOCK            (clock),
        .iRESET            (reset),
        .iFREE_RESTART     (freeRestart),
        .iREQ_VALID        (reqValid),
        .oREQ_LOCK         (satLock),
        .iREQ_TAG          (reqTag),
        .iREQ_KIND         (reqKind),
        .iREQ_TAKEN        (reqTaken),
        .iREQ_PC           (reqPc),
        .iREQ_TARGET       (reqTarget),
        .iREQ_PRED_TAKEN   (reqPredTaken),
        .iREQ_PRED_ADDR    (reqPredAddr),
        .iREQ_SWI_NUM      (reqSwiNum),
        .oCMP_VALID        (satCmpValid),
        .oCMP_TAG          (satCmpTag),
        .oREDIRECT_VALID   (satRedirValid),
        .iREDIRECT_READY   (redirectReady),
        .oREDIRECT_KIND    (satRedirKind),
        .oREDIRECT_ADDR    (satRedirAddr),
        .oREDIRECT_TAG     (satRedirTag),
        .oREDIRECT_SWI_NUM (satRedirSwi),
        .oMISPRED_CNT      (satCnt)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", name, observed, expected, $time);
        end
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input bit valid, input logic [5:0] tag, input logic [1:0] kind,
                                 input bit taken, input logic [31:0] pc, input logic [31:0] target,
                                 input bit predTaken, input logic [31:0] predAddr,
                                 input logic [10:0] swi, input bit ready, input bit restart);
        reqValid      = valid;
        reqTag        = tag;
        reqKind       = kind;
        reqTaken      = taken;
        reqPc         = pc;
        reqTarget     = target;
        reqPredTaken  = predTaken;
        reqPredAddr   = predAddr;
        reqSwiNum     = swi;
        redirectReady = ready;
        freeRestart   = restart;
    endtask

    task automatic idleInputs(input bit ready, input bit restart);
        applyStimulus(1'b0, 6'd0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 11'd0, ready, restart);
    endtask

    task automatic resetModel();
        mPend     = 1'b0;
        mShadow   = 1'b0;
        mCmpValid = 1'b0;
        mCmpTag   = '0;
        mKind     = '0;
        mAddr     = '0;
        mTag      = '0;
        mSwi      = '0;
        mCnt      = 0;
        mCntSat   = 0;
    endtask

    task automatic compareAll();
        checkOutput("lock",       reqLock,    mPend || mShadow);
        checkOutput("cmpValid",   cmpValid,   mCmpValid);
        checkOutput("cmpTag",     cmpTag,     mCmpTag);
        checkOutput("redirValid", redirValid, mPend);
        checkOutput("redirKind",  redirKind,  mKind);
        checkOutput("redirAddr",  redirAddr,  mAddr);
        checkOutput("redirTag",   redirTag,   mTag);
        checkOutput("redirSwi",   redirSwi,   mSwi);
        checkOutput("mispredCnt", mispredCnt, 64'(mCnt));
        checkOutput("satLock",    satLock,    mPend || mShadow);
        checkOutput("satCmpValid", satCmpValid, mCmpValid);
        checkOutput("satRedirValid", satRedirValid, mPend);
        checkOutput("satCnt",     satCnt,     64'(mCntSat));
    endtask

    // Apply the current inputs at the next rising edge: predict the result
    // from the port's rules, then check all outputs just after the edge.
    task automatic stepCycle();
        bit locked;
        bit accept;
        bit mis;
        bit redir;
        locked = mPend || mShadow;
        accept = reqValid && !locked && !freeRestart;
        mis    = (reqTaken != reqPredTaken) || (reqTaken && (reqTarget != reqPredAddr));
        redir  = (reqKind != 2'd0) || mis;
        if (freeRestart) begin
            mPend   = 1'b0;
            mShadow = 1'b0;
        end else if (mPend && redirectReady) begin
            mPend   = 1'b0;
            mShadow = 1'b1;
        end
        mCmpValid = accept;
        if (accept) begin
            mCmpTag = reqTag;
            if (redir) begin
                mPend = 1'b1;
                mKind = reqKind;
                mAddr = (reqKind == 2'd0 && !reqTaken) ? reqPc + 32'd4 : reqTarget;
                mTag  = reqTag;
                mSwi  = reqSwiNum;
            end
            if (reqKind == 2'd0 && mis) begin
                if (mCnt < 65535) mCnt++;
                if (mCntSat < 3) mCntSat++;
            end
        end
        @(posedge clock);
        #1;
        compareAll();
    endtask

    initial begin
        resetModel();
        reset = 1'b1;
        idleInputs(1'b0, 1'b0);
        #12;
        compareAll();
        @(negedge clock);
        reset = 1'b0;

        // Correctly predicted taken jump: completion only.
        applyStimulus(1'b1, 6'd5, 2'd0, 1'b1, 32'h80, 32'h100, 1'b1, 32'h100, 11'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("planCmpTag5", cmpTag, 6'd5);

        // Not-taken jump predicted taken: redirect to PC+4, then stall on READY.
        applyStimulus(1'b1, 6'd7, 2'd0, 1'b0, 32'h200, 32'h999, 1'b1, 32'h999, 11'd0, 1'b0, 1'b0);
        stepCycle();
        checkOutput("planRedirAddr", redirAddr, 32'h204);
        checkOutput("planCnt1", mispredCnt, 16'd1);
        for (int i = 0; i < 3; i++) begin
            idleInputs(1'b0, 1'b0);
            stepCycle();
        end
        idleInputs(1'b1, 1'b0);
        stepCycle();
        idleInputs(1'b0, 1'b1);
        stepCycle();
        checkOutput("planUnlocked", reqLock, 1'b0);

        // Back-to-back correctly predicted jumps.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 6'(i), 2'd0, 1'b1, 32'h400, 32'h500, 1'b1, 32'h500, 11'd0, 1'b0, 1'b0);
            stepCycle();
        end

        // SWI, then a request while locked, then restart with READY and a request.
        applyStimulus(1'b1, 6'd9, 2'd3, 1'b0, 32'h600, 32'h3000, 1'b0, 32'h0, 11'h155, 1'b0, 1'b0);
        stepCycle();
        checkOutput("planSwiNum", redirSwi, 11'h155);
        applyStimulus(1'b1, 6'd10, 2'd0, 1'b1, 32'h700, 32'h800, 1'b1, 32'h800, 11'd0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 6'd11, 2'd1, 1'b0, 32'h700, 32'h900, 1'b0, 32'h0, 11'd0, 1'b1, 1'b1);
        stepCycle();
        checkOutput("planRestartDrop", redirValid, 1'b0);

        // Five mispredictions push the narrow counter into saturation.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 6'(20 + i), 2'd0, 1'b1, 32'h1000, 32'h2000, 1'b0, 32'h0, 11'd0, 1'b0, 1'b0);
            stepCycle();
            idleInputs(1'b1, 1'b0);
            stepCycle();
            idleInputs(1'b0, 1'b1);
            stepCycle();
        end
        checkOutput("planSatCnt", satCnt, 2'd3);

        // Reset in the middle of a pending redirect clears everything at once.
        applyStimulus(1'b1, 6'd30, 2'd2, 1'b0, 32'h1100, 32'h4000, 1'b0, 32'h0, 11'd0, 1'b0, 1'b0);
        stepCycle();
        idleInputs(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        resetModel();
        compareAll();
        @(negedge clock);
        reset = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          valid;
            bit          taken;
            bit          predTaken;
            bit          ready;
            bit          restart;
            logic [1:0]  kind;
            logic [31:0] pc;
            logic [31:0] target;
            logic [31:0] predAddr;
            valid     = ($urandom_range(0, 3) != 0);
            kind      = ($urandom_range(0, 7) >= 6) ? 2'($urandom_range(1, 3)) : 2'd0;
            taken     = 1'($urandom);
            predTaken = ($urandom_range(0, 3) == 0) ? !taken : taken;
            pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            target    = $urandom;
            predAddr  = ($urandom_range(0, 3) == 0) ? $urandom : target;
            ready     = 1'($urandom);
            restart   = mShadow ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            applyStimulus(valid, 6'($urandom), kind, taken, pc, target, predTaken, predAddr,
                          11'($urandom), ready, restart);
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
